l0_store_buffer: RTL and testbench

Write-through store buffer downstream of the L0 data cache. Committed stores are written into the L0 cache and, in the same cycle, enqueued here; the buffer drains them in order to data memory through a valid/ready request port. It flags load hazards against pending stores so a load is not serviced from memory ahead of an older store. It also provides a fence/drain handshake for FENCE and AMO ordering.

---
 rtl/l0_store_buffer_if.sv | 40 ++++
 rtl/l0_store_buffer.sv | 121 ++++++++++++
 tb/tb_l0_store_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/l0_store_buffer_if.sv
// Store-buffer bundle: store enqueue, memory request, load check, fence and status.
// The slave modport is the buffer itself; master is the core/memory side driving it.
interface l0_store_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              i_store_valid;
    logic [31:0]       i_store_addr;
    logic [XLEN-1:0]   i_store_data;
    logic [XLEN/8-1:0] i_store_byte_en;
    logic              o_store_ready;
    logic              o_mem_req_valid;
    logic [31:0]       o_mem_req_addr;
    logic [XLEN-1:0]   o_mem_req_data;
    logic [XLEN/8-1:0] o_mem_req_byte_en;
    logic              i_mem_req_ready;
    logic              i_load_check_valid;
    logic [31:0]       i_load_check_addr;
    logic              o_load_conflict;
    logic              i_fence_req;
    logic              o_fence_done;
    logic              o_empty;
    logic [CW-1:0]     o_count;

    modport slave (
        input  i_store_valid, i_store_addr, i_store_data, i_store_byte_en,
        input  i_mem_req_ready, i_load_check_valid, i_load_check_addr, i_fence_req,
        output o_store_ready, o_mem_req_valid, o_mem_req_addr, o_mem_req_data,
        output o_mem_req_byte_en, o_load_conflict, o_fence_done, o_empty, o_count
    );

    modport master (
        output i_store_valid, i_store_addr, i_store_data, i_store_byte_en,
        output i_mem_req_ready, i_load_check_valid, i_load_check_addr, i_fence_req,
        input  o_store_ready, o_mem_req_valid, o_mem_req_addr, o_mem_req_data,
        input  o_mem_req_byte_en, o_load_conflict, o_fence_done, o_empty, o_count
    );
endinterface

// File: rtl/l0_store_buffer.sv
// Write-through store buffer behind the L0 D-cache: in-order drain to memory,
// load-hazard detection against pending stores, and a fence/drain handshake.
module l0_store_buffer #(
    parameter int          DEPTH     = 4,
    parameter int          XLEN      = 32,
    parameter logic [31:0] MMIO_ADDR = 32'h4000_0000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    l0_store_buffer_if.slave sb
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int BW = XLEN / 8;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [1:0]    ST_IDLE  = 2'b00;
    localparam logic [1:0]    ST_DRAIN = 2'b01;
    localparam logic [1:0]    ST_DONE  = 2'b10;

    logic [31:0]     addr_mem_r [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [BW-1:0]   be_mem_r   [DEPTH];
    logic [IW-1:0]   off_s      [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] count_s;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          ready_s;
    logic          enq_s;
    logic          deq_s;
    logic          hit_buffer_s;
    logic          hit_incoming_s;
    logic          mmio_order_s;

    assign full_s  = (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]) && (wr_ptr_r[IW] != rd_ptr_r[IW]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign count_s = wr_ptr_r - rd_ptr_r;
    // A full buffer never accepts, even when the head leaves in the same cycle.
    assign ready_s = ~full_s & (state_r != ST_DRAIN);
    assign enq_s   = sb.i_store_valid & ready_s;
    assign deq_s   = ~empty_s & sb.i_mem_req_ready;

    // Entry payload storage; contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (enq_s) begin
            addr_mem_r[wr_ptr_r[IW-1:0]] <= sb.i_store_addr;
            data_mem_r[wr_ptr_r[IW-1:0]] <= sb.i_store_data;
            be_mem_r[wr_ptr_r[IW-1:0]]   <= sb.i_store_byte_en;
        end
    end

    // Pointer and fence-state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            state_r  <= ST_IDLE;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            state_r <= state_nxt_s;
        end
    end

    // Fence sequencing: DRAIN ends once the last pending store is leaving.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sb.i_fence_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (empty_s || ((count_s == PTR_ONE) && deq_s)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Word-granular hazard match; the entry offset from the head decides occupancy.
    always_comb begin
        hit_buffer_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off_s[i]     = IW'(i) - rd_ptr_r[IW-1:0];
            hit_buffer_s = hit_buffer_s
                         | (({1'b0, off_s[i]} < count_s)
                            && (addr_mem_r[i][31:2] == sb.i_load_check_addr[31:2])
                            && (|be_mem_r[i]));
        end
    end

    assign hit_incoming_s = enq_s && (sb.i_store_addr[31:2] == sb.i_load_check_addr[31:2])
                            && (|sb.i_store_byte_en);
    assign mmio_order_s   = (sb.i_load_check_addr >= MMIO_ADDR) && ~empty_s;

    assign sb.o_load_conflict   = sb.i_load_check_valid & (hit_buffer_s | hit_incoming_s | mmio_order_s);
    assign sb.o_store_ready     = ready_s;
    assign sb.o_mem_req_valid   = ~empty_s;
    assign sb.o_mem_req_addr    = {addr_mem_r[rd_ptr_r[IW-1:0]][31:2], 2'b00};
    assign sb.o_mem_req_data    = data_mem_r[rd_ptr_r[IW-1:0]];
    assign sb.o_mem_req_byte_en = be_mem_r[rd_ptr_r[IW-1:0]];
    assign sb.o_fence_done      = (state_r == ST_DONE);
    assign sb.o_empty           = empty_s;
    assign sb.o_count           = count_s;
endmodule

// File: tb/tb_l0_store_buffer.sv
// Directed bench for l0_store_buffer (DEPTH=4, XLEN=32): each scenario task drives
// stimulus and compares against hand-computed expectations.
module tb_l0_store_buffer;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 i_clk = ~i_clk;

    l0_store_buffer_if #(.XLEN(32), .DEPTH(4)) sb_if ();

    l0_store_buffer #(.DEPTH(4), .XLEN(32), .MMIO_ADDR(32'h4000_0000)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .sb    (sb_if.slave)
    );

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic put_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        sb_if.i_store_valid   = 1'b1;
        sb_if.i_store_addr    = addr;
        sb_if.i_store_data    = data;
        sb_if.i_store_byte_en = be;
        tick();
        sb_if.i_store_valid   = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        sb_if.i_store_valid = 1'b0;      sb_if.i_store_addr = 32'h0;
        sb_if.i_store_data = 32'h0;      sb_if.i_store_byte_en = 4'h0;
        sb_if.i_mem_req_ready = 1'b0;    sb_if.i_load_check_valid = 1'b0;
        sb_if.i_load_check_addr = 32'h0; sb_if.i_fence_req = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        tick();
        checks++; if (sb_if.o_store_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b expected=1", sb_if.o_store_ready); end
        checks++; if (sb_if.o_empty !== 1'b1) begin failures++; $display("FAIL reset_empty actual=%b expected=1", sb_if.o_empty); end
        checks++; if (sb_if.o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", sb_if.o_mem_req_valid); end
        checks++; if (sb_if.o_count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", sb_if.o_count); end
        checks++; if (sb_if.o_fence_done !== 1'b0) begin failures++; $display("FAIL reset_fence_done actual=%b expected=0", sb_if.o_fence_done); end
        checks++; if (sb_if.o_load_conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict actual=%b expected=0", sb_if.o_load_conflict); end
    endtask

    task automatic test_enqueue_hold;
        sb_if.i_mem_req_ready = 1'b0;
        put_store(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        for (int c = 0; c < 4; c++) begin
            checks++; if (sb_if.o_mem_req_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] actual=%b expected=1", c, sb_if.o_mem_req_valid); end
            checks++; if (sb_if.o_mem_req_addr !== 32'h0000_0100) begin failures++; $display("FAIL hold_addr[%0d] actual=%h expected=00000100", c, sb_if.o_mem_req_addr); end
            checks++; if (sb_if.o_mem_req_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_data[%0d] actual=%h expected=deadbeef", c, sb_if.o_mem_req_data); end
            checks++; if (sb_if.o_mem_req_byte_en !== 4'hF) begin failures++; $display("FAIL hold_be[%0d] actual=%h expected=f", c, sb_if.o_mem_req_byte_en); end
            if (c < 3) tick();
        end
        checks++; if (sb_if.o_count !== 3'd1) begin failures++; $display("FAIL hold_count actual=%0d expected=1", sb_if.o_count); end
        sb_if.i_mem_req_ready = 1'b1;
        tick();
        sb_if.i_mem_req_ready = 1'b0;
        checks++; if (sb_if.o_empty !== 1'b1) begin failures++; $display("FAIL drain_empty actual=%b expected=1", sb_if.o_empty); end
        checks++; if (sb_if.o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL drain_valid actual=%b expected=0", sb_if.o_mem_req_valid); end
    endtask

    task automatic test_fifo_wrap;
        logic [31:0] exp_addr_q[$];
        logic [31:0] exp_data_q[$];
        logic [31:0] a_v;
        logic [31:0] d_v;
        int sent;
        int got;
        sb_if.i_mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_v = 32'h0000_1000 + 32'(i) * 32'd4 + 32'(i % 4);
            d_v = 32'hA500_0000 + 32'(i);
            exp_addr_q.push_back({a_v[31:2], 2'b00});
            exp_data_q.push_back(d_v);
            put_store(a_v, d_v, 4'hF);
        end
        checks++; if (sb_if.o_store_ready !== 1'b0) begin failures++; $display("FAIL full_ready actual=%b expected=0", sb_if.o_store_ready); end
        checks++; if (sb_if.o_count !== 3'd4) begin failures++; $display("FAIL full_count actual=%0d expected=4", sb_if.o_count); end
        put_store(32'h0000_0BAD, 32'hBADB_AD00, 4'hF);
        checks++; if (sb_if.o_count !== 3'd4) begin failures++; $display("FAIL full_reject_count actual=%0d expected=4", sb_if.o_count); end
        sent = 4;
        got  = 0;
        for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
            sb_if.i_mem_req_ready = 1'b1;
            if (sb_if.o_store_ready && sent < 16) begin
                a_v = 32'h0000_1000 + 32'(sent) * 32'd4 + 32'(sent % 4);
                d_v = 32'hA500_0000 + 32'(sent);
                sb_if.i_store_valid = 1'b1;  sb_if.i_store_addr = a_v;
                sb_if.i_store_data  = d_v;   sb_if.i_store_byte_en = 4'hF;
                exp_addr_q.push_back({a_v[31:2], 2'b00});
                exp_data_q.push_back(d_v);
                sent++;
            end else begin
                sb_if.i_store_valid = 1'b0;
            end
            #1;
            if (sb_if.o_mem_req_valid) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++; $display("FAIL wrap_extra actual=%h expected=none", sb_if.o_mem_req_addr);
                end else if (sb_if.o_mem_req_addr !== exp_addr_q[0] || sb_if.o_mem_req_data !== exp_data_q[0]) begin
                    failures++; $display("FAIL wrap_order[%0d] actual=%h/%h expected=%h/%h", got, sb_if.o_mem_req_addr, sb_if.o_mem_req_data, exp_addr_q[0], exp_data_q[0]);
                end
                if (exp_addr_q.size() != 0) begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
                got++;
            end
            tick();
        end
        sb_if.i_store_valid = 1'b0;
        sb_if.i_mem_req_ready = 1'b0;
        checks++; if (got != 16) begin failures++; $display("FAIL wrap_total actual=%0d expected=16", got); end
        checks++; if (sb_if.o_count !== 3'd0) begin failures++; $display("FAIL wrap_count actual=%0d expected=0", sb_if.o_count); end
    endtask

    task automatic test_load_conflict;
        sb_if.i_mem_req_ready = 1'b0;
        put_store(32'h0000_0204, 32'h0000_0011, 4'h1);
        sb_if.i_load_check_valid = 1'b1;
        sb_if.i_load_check_addr = 32'h0000_0206; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b1) begin failures++; $display("FAIL ld_same_word actual=%b expected=1", sb_if.o_load_conflict); end
        sb_if.i_load_check_addr = 32'h0000_0208; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b0) begin failures++; $display("FAIL ld_other_word actual=%b expected=0", sb_if.o_load_conflict); end
        sb_if.i_load_check_addr = 32'h4000_0000; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b1) begin failures++; $display("FAIL ld_mmio_pending actual=%b expected=1", sb_if.o_load_conflict); end
        sb_if.i_load_check_addr = 32'h0000_020C;
        sb_if.i_store_valid = 1'b1; sb_if.i_store_addr = 32'h0000_020E;
        sb_if.i_store_data = 32'h0; sb_if.i_store_byte_en = 4'h4; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b1) begin failures++; $display("FAIL ld_incoming actual=%b expected=1", sb_if.o_load_conflict); end
        sb_if.i_store_valid = 1'b0;
        sb_if.i_load_check_valid = 1'b0;
        sb_if.i_load_check_addr = 32'h0000_0204; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b0) begin failures++; $display("FAIL ld_not_valid actual=%b expected=0", sb_if.o_load_conflict); end
        sb_if.i_load_check_valid = 1'b1;
        sb_if.i_mem_req_ready = 1'b1; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b1) begin failures++; $display("FAIL ld_dequeuing actual=%b expected=1", sb_if.o_load_conflict); end
        tick();
        sb_if.i_mem_req_ready = 1'b0;
        sb_if.i_load_check_addr = 32'h4000_0000; #1;
        checks++; if (sb_if.o_load_conflict !== 1'b0) begin failures++; $display("FAIL ld_mmio_empty actual=%b expected=0", sb_if.o_load_conflict); end
        sb_if.i_load_check_valid = 1'b0;
    endtask

    task automatic test_fence;
        sb_if.i_mem_req_ready = 1'b0;
        put_store(32'h0000_0400, 32'h1, 4'hF);
        put_store(32'h0000_0404, 32'h2, 4'hF);
        put_store(32'h0000_0408, 32'h3, 4'hF);
        sb_if.i_fence_req = 1'b1;
        tick();
        sb_if.i_store_valid = 1'b1; sb_if.i_store_addr = 32'h0000_040C; #1;
        checks++; if (sb_if.o_store_ready !== 1'b0) begin failures++; $display("FAIL fence_ready actual=%b expected=0", sb_if.o_store_ready); end
        sb_if.i_store_valid = 1'b0;
        sb_if.i_mem_req_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            checks++; if (sb_if.o_fence_done !== 1'b0) begin failures++; $display("FAIL fence_early[%0d] actual=%b expected=0", d, sb_if.o_fence_done); end
            tick();
        end
        sb_if.i_mem_req_ready = 1'b0;
        checks++; if (sb_if.o_fence_done !== 1'b1) begin failures++; $display("FAIL fence_pulse actual=%b expected=1", sb_if.o_fence_done); end
        checks++; if (sb_if.o_count !== 3'd0) begin failures++; $display("FAIL fence_count actual=%0d expected=0", sb_if.o_count); end
        sb_if.i_fence_req = 1'b0;
        tick();
        checks++; if (sb_if.o_fence_done !== 1'b0) begin failures++; $display("FAIL fence_single actual=%b expected=0", sb_if.o_fence_done); end
        sb_if.i_fence_req = 1'b1;
        tick();
        checks++; if (sb_if.o_fence_done !== 1'b0) begin failures++; $display("FAIL fence_empty_early actual=%b expected=0", sb_if.o_fence_done); end
        tick();
        sb_if.i_fence_req = 1'b0;
        checks++; if (sb_if.o_fence_done !== 1'b1) begin failures++; $display("FAIL fence_empty_pulse actual=%b expected=1", sb_if.o_fence_done); end
        tick();
        checks++; if (sb_if.o_store_ready !== 1'b1) begin failures++; $display("FAIL fence_release_ready actual=%b expected=1", sb_if.o_store_ready); end
    endtask

    task automatic test_reset_mid;
        sb_if.i_mem_req_ready = 1'b0;
        put_store(32'h0000_0500, 32'h5, 4'hF);
        put_store(32'h0000_0504, 32'h6, 4'hF);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if (sb_if.o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid actual=%b expected=0", sb_if.o_mem_req_valid); end
        checks++; if (sb_if.o_count !== 3'd0) begin failures++; $display("FAIL rstmid_count actual=%0d expected=0", sb_if.o_count); end
        put_store(32'h0000_0300, 32'h3333_3333, 4'h3);
        checks++; if (sb_if.o_mem_req_addr !== 32'h0000_0300 || sb_if.o_mem_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_first actual=%h/%b expected=00000300/1", sb_if.o_mem_req_addr, sb_if.o_mem_req_valid); end
        checks++; if (sb_if.o_mem_req_data !== 32'h3333_3333) begin failures++; $display("FAIL rstmid_data actual=%h expected=33333333", sb_if.o_mem_req_data); end
        sb_if.i_mem_req_ready = 1'b1;
        tick();
        sb_if.i_mem_req_ready = 1'b0;
        checks++; if (sb_if.o_empty !== 1'b1) begin failures++; $display("FAIL rstmid_drain actual=%b expected=1", sb_if.o_empty); end
    endtask

    initial begin
        test_reset();
        test_enqueue_hold();
        test_fifo_wrap();
        test_load_conflict();
        test_fence();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
